fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the synchronous-read instruction memory. It owns the program counter, issues one read request per cycle, and pairs each returned word with its PC for the IF/ID register. It also applies stalls, back-end redirects (mispredict, jump, trap) and front-end predicted-taken redirects. The memory returns data one cycle after a request and holds its output while the read enable is low; this block relies on that hold to implement stalls without a skid buffer.

---
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one synchronous-read request per cycle
// and pairs each returned word with its address for the IF/ID register.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        pred_taken_i,
   input  logic [31:0] pred_target_i,
   output logic        imem_rden_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] req_addr;
   logic        req_en;

   // Targets are word addresses; the low two bits are dropped by construction.
   logic unused_low_bits;
   assign unused_low_bits = ^{redirect_pc_i[1:0], pred_target_i[1:0]};

   always_comb begin
      req_addr = pc_q;
      if (redirect_i) begin
         req_addr = {redirect_pc_i[31:2], 2'b00};
      end else if (out_valid_q && pred_taken_i) begin
         req_addr = {pred_target_i[31:2], 2'b00};
      end

      // A redirect must be issued even while stalled so the target is next on the output.
      req_en = ~rst_i & (redirect_i | ~stall_i);

      pc_d        = pc_q;
      out_pc_d    = out_pc_q;
      out_valid_d = out_valid_q;
      if (req_en) begin
         pc_d        = req_addr + 32'd4;
         out_pc_d    = req_addr;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q        <= {RESET_PC[31:2], 2'b00};
         out_pc_q    <= 32'h0000_0000;
         out_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         out_pc_q    <= out_pc_d;
         out_valid_q <= out_valid_d;
      end
   end

   // While stalled the memory holds its read data, keeping instr_o paired with pc_o.
   assign imem_rden_o = req_en;
   assign imem_addr_o = req_addr;
   assign instr_o     = imem_data_i;
   assign pc_o        = out_pc_q;
   assign pc_plus4_o  = out_pc_q + 32'd4;
   assign valid_o     = out_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle vectors feed a scoreboard of expected PCs,
// a negedge monitor pops and compares every accepted output word.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        imem_rden;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = 32'h0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        valid;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic [31:0] exp_q[$];

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .pred_taken_i(pred_taken), .pred_target_i(pred_target),
      .imem_rden_o(imem_rden), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4), .valid_o(valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous-read memory that holds its output while the read enable is low.
   always @(posedge clk) begin
      if (imem_rden === 1'b1) imem_data <= memf(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every word accepted downstream (valid, not stalled) must match the scoreboard.
   always @(negedge clk) begin
      if (mon_en && valid === 1'b1 && stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h expected no word", pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", pc, e);
            chk("sb_instr", instr, memf(e));
            chk("sb_pc_plus4", pc_plus4, e + 32'd4);
            $display("word pc=%h instr=%h pc_plus4=%h (expected pc %h)", pc, instr, pc_plus4, e);
         end
      end
   end

   task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                      input logic pt, input logic [31:0] ptgt,
                      input logic exp_rden, input logic [31:0] exp_addr,
                      input logic exp_valid, input logic [31:0] exp_pc);
      @(posedge clk);
      #1;
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      pred_taken = pt; pred_target = ptgt;
      if (exp_valid && !s) exp_q.push_back(exp_pc);
      #2;
      chk("rden", {31'h0, imem_rden}, {31'h0, exp_rden});
      chk("addr", imem_addr, exp_addr);
      chk("valid", {31'h0, valid}, {31'h0, exp_valid});
      if (exp_valid && s) begin
         chk("stall_pc", pc, exp_pc);
         chk("stall_instr", instr, memf(exp_pc));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      pred_taken = 1'b0; pred_target = 32'h0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      chk("rst_rden", {31'h0, imem_rden}, 32'h0);
      mon_en = 1'b1;

      //  rst  stl  red  rpc           pt   ptgt          rden addr          vld  pc
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0100,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0104,1'b1,32'h0000_0100);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0108,1'b1,32'h0000_0104);
      // three-cycle stall holding pc 108
      cyc(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_010C,1'b1,32'h0000_0108);
      cyc(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_010C,1'b1,32'h0000_0108);
      cyc(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_010C,1'b1,32'h0000_0108);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_010C,1'b1,32'h0000_0108);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0110,1'b1,32'h0000_010C);
      // back-end redirect with unaligned target
      cyc(1'b0,1'b0,1'b1,32'h0000_0203,1'b0,32'h0,        1'b1,32'h0000_0200,1'b1,32'h0000_0110);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0204,1'b1,32'h0000_0200);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0208,1'b1,32'h0000_0204);
      cyc(1'b0,1'b0,1'b1,32'h0000_0120,1'b0,32'h0,        1'b1,32'h0000_0120,1'b1,32'h0000_0208);
      // predicted-taken redirect from pc 120
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0400,1'b1,32'h0000_0400,1'b1,32'h0000_0120);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0404,1'b1,32'h0000_0400);
      // redirect beats prediction
      cyc(1'b0,1'b0,1'b1,32'h0000_0500,1'b1,32'h0000_0400,1'b1,32'h0000_0500,1'b1,32'h0000_0404);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0504,1'b1,32'h0000_0500);
      // redirect during stall still issues; stalled word 504 is lost
      cyc(1'b0,1'b1,1'b1,32'h0000_0600,1'b0,32'h0,        1'b1,32'h0000_0600,1'b1,32'h0000_0504);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0604,1'b1,32'h0000_0600);
      // wrap-around at the top of the address space
      cyc(1'b0,1'b0,1'b1,32'hFFFF_FFFE,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b1,32'h0000_0604);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0000,1'b1,32'hFFFF_FFFC);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0004,1'b1,32'h0000_0000);
      // mid-stream reset: no request, then refetch from RESET_PC with prediction ignored
      cyc(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,1'b1,32'h0000_0004);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0700,1'b1,32'h0000_0100,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0104,1'b1,32'h0000_0100);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0108,1'b1,32'h0000_0104);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_010C,1'b1,32'h0000_0108);

      @(posedge clk);
      #3;
      chk("sb_drained", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
